// File: rtl/keys_pio_pkg.sv
// Shared register map and helpers for the keys_edge_pio input PIO.
// Optional debounce is enabled by defining KEYS_DEBOUNCE_EN.
package keys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // One spare bit so the terminal count is always representable.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer: output follows a synchronised input only after it has
// been stable for CYCLES clocks. Reduces to a bypass wire unless KEYS_DEBOUNCE_EN.
module pio_debounce
  import keys_pio_pkg::*;
#(
  parameter int unsigned CYCLES = 50000,
  parameter bit          IDLE   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

`ifdef KEYS_DEBOUNCE_EN
  localparam int CW = cnt_width(int'(CYCLES));

  logic [CW-1:0] cnt_r;
  logic          stable_r;

  // Count consecutive cycles of disagreement; accept the new level at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CW{1'b0}};
      stable_r <= IDLE;
    end else if (din != stable_r) begin
      if (cnt_r == CW'(CYCLES - 32'd1)) begin
        stable_r <= din;
        cnt_r    <= {CW{1'b0}};
      end else begin
        cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  assign dout = stable_r;
`else
  localparam int unsigned unused_cycles = CYCLES;
  localparam bit          unused_idle   = IDLE;
  logic unused_s;

  assign unused_s = clk ^ reset_n;
  assign dout     = din;
`endif

endmodule

// File: rtl/keys_edge_pio.sv
// Avalon-MM input PIO: synchronised (optionally debounced via KEYS_DEBOUNCE_EN)
// pins, sticky edge capture with W1C, maskable registered level IRQ.
module keys_edge_pio
  import keys_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          CAPTURE_FALLING = 1'b1,
  parameter bit          IDLE_HIGH       = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_V = {WIDTH{IDLE_HIGH}};

  logic [WIDTH-1:0] sync1_r, sync2_r, stable_s, prev_r;
  logic [WIDTH-1:0] edge_s, cap_r, cap_next_s, mask_r, wdata_s;
  logic             we_s, irq_r, unused_s;

  assign we_s     = chipselect & ~write_n;
  assign wdata_s  = writedata[WIDTH-1:0];
  assign unused_s = ^writedata;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= IDLE_V;
      sync2_r <= IDLE_V;
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
    pio_debounce #(
      .CYCLES (DEBOUNCE_CYCLES),
      .IDLE   (IDLE_HIGH)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync2_r[i]),
      .dout    (stable_s[i])
    );
  end

  // Edge polarity select.
  always_comb begin
    if (CAPTURE_FALLING) begin
      edge_s = prev_r & ~stable_s;
    end else begin
      edge_s = ~prev_r & stable_s;
    end
  end

  // W1C is applied before OR-ing in new edges so a same-cycle set survives.
  always_comb begin
    if (we_s && (address == ADDR_EDGECAP)) begin
      cap_next_s = (cap_r & ~wdata_s) | edge_s;
    end else begin
      cap_next_s = cap_r | edge_s;
    end
  end

  // Edge history, capture, mask and registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= IDLE_V;
      cap_r  <= {WIDTH{1'b0}};
      mask_r <= {WIDTH{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      prev_r <= stable_s;
      cap_r  <= cap_next_s;
      irq_r  <= |(cap_r & mask_r);
      if (we_s && (address == ADDR_IRQMASK)) begin
        mask_r <= wdata_s;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Zero-wait read mux; fields are zero-extended.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable_s;
      ADDR_DIR:     readdata = 32'd0;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_r;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_r;
      default:      readdata = 32'd0;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_keys_edge_pio.sv
// Directed self-checking bench for keys_edge_pio; debounce cases run when
// KEYS_DEBOUNCE_EN is defined, otherwise the direct-sync register/IRQ cases run.
module tb_keys_edge_pio;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          chipselect;
  logic [1:0]    address;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  keys_edge_pio #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (8),
    .CAPTURE_FALLING (1'b1),
    .IDLE_HIGH       (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pin;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    int          cyc;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    write_n   = 1'b1;
    writedata = 32'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl [17];
    int   lat;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    in_port    = 4'hF;
    tick(3);
    rd_check("reset data", 2'd0, 32'h0000000F);
    rd_check("reset mask", 2'd2, 32'd0);
    rd_check("reset cap",  2'd3, 32'd0);
    check("reset irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

`ifndef KEYS_DEBOUNCE_EN
    //         pin    wr    waddr  wdata          cyc rd     exp_rd         irq
    tbl[0]  = '{4'hF, 1'b0, 2'd0, 32'd0,          2, 2'd0, 32'h0000000F, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 2'd0, 32'd0,          1, 2'd2, 32'd0,        1'b0};
    tbl[2]  = '{4'hF, 1'b0, 2'd0, 32'd0,          0, 2'd3, 32'd0,        1'b0};
    tbl[3]  = '{4'hE, 1'b0, 2'd0, 32'd0,          2, 2'd0, 32'h0000000E, 1'b0};
    tbl[4]  = '{4'hE, 1'b0, 2'd0, 32'd0,          1, 2'd3, 32'h00000001, 1'b0};
    tbl[5]  = '{4'hE, 1'b1, 2'd2, 32'h00000001,   0, 2'd2, 32'h00000001, 1'b0};
    tbl[6]  = '{4'hE, 1'b0, 2'd0, 32'd0,          1, 2'd2, 32'h00000001, 1'b1};
    tbl[7]  = '{4'hC, 1'b0, 2'd0, 32'd0,          3, 2'd3, 32'h00000003, 1'b1};
    tbl[8]  = '{4'hC, 1'b1, 2'd3, 32'h00000001,   0, 2'd3, 32'h00000002, 1'b1};
    tbl[9]  = '{4'hC, 1'b0, 2'd0, 32'd0,          1, 2'd3, 32'h00000002, 1'b0};
    tbl[10] = '{4'hC, 1'b1, 2'd2, 32'hFFFFFFF3,   1, 2'd2, 32'h00000003, 1'b1};
    tbl[11] = '{4'hC, 1'b1, 2'd0, 32'd0,          0, 2'd0, 32'h0000000C, 1'b1};
    tbl[12] = '{4'hC, 1'b0, 2'd0, 32'd0,          0, 2'd1, 32'd0,        1'b1};
    tbl[13] = '{4'hC, 1'b1, 2'd1, 32'h0000000F,   0, 2'd1, 32'd0,        1'b1};
    tbl[14] = '{4'hC, 1'b1, 2'd3, 32'h0000000F,   1, 2'd3, 32'd0,        1'b0};
    tbl[15] = '{4'hF, 1'b0, 2'd0, 32'd0,          4, 2'd0, 32'h0000000F, 1'b0};
    tbl[16] = '{4'hF, 1'b0, 2'd0, 32'd0,          0, 2'd3, 32'd0,        1'b0};

    for (int i = 0; i < 17; i++) begin
      in_port = tbl[i].pin;
      if (tbl[i].wr_en) wr(tbl[i].wr_addr, tbl[i].wr_data);
      tick(tbl[i].cyc);
      rd_check($sformatf("vec%0d rd", i), tbl[i].rd_addr, tbl[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end

    // Falling edge on bit0 lands in the same cycle as a W1C of bit0: set wins.
    in_port = 4'hE;
    tick(2);
    wr(2'd3, 32'h00000001);
    rd_check("collision cap", 2'd3, 32'h00000001);
    tick(1);
    check("collision irq", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h00000001);
    tick(1);
    rd_check("post clear cap", 2'd3, 32'd0);
    check("post clear irq", {31'd0, irq}, 32'd0);

    // Reset while a low level is partway through the synchroniser.
    in_port = 4'hF;
    tick(4);
    in_port = 4'h0;
    tick(1);
    reset_n = 1'b0;
    #1;
    rd_check("mid reset data", 2'd0, 32'h0000000F);
    rd_check("mid reset mask", 2'd2, 32'd0);
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(5);
    rd_check("after reset data", 2'd0, 32'h0000000F);
    rd_check("after reset cap",  2'd3, 32'd0);
    check("after reset irq", {31'd0, irq}, 32'd0);
`else
    tick(2);
    // 5-cycle glitch must never reach DATA or capture.
    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      rd_check($sformatf("glitch data c%0d", i), 2'd0, 32'h0000000F);
    end
    rd_check("glitch cap", 2'd3, 32'd0);

    // Sustained low is accepted after synchroniser plus debounce time.
    in_port = 4'hE;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      address = 2'd0;
      #1;
      if (lat == 0 && readdata[0] == 1'b0) lat = i;
    end
    check("debounce latency window", {31'd0, (lat >= 10) && (lat <= 11)}, 32'd1);
    rd_check("debounce data", 2'd0, 32'h0000000E);
    rd_check("debounce cap",  2'd3, 32'h00000001);
    in_port = 4'hF;
    tick(15);
    rd_check("debounce release", 2'd0, 32'h0000000F);
    wr(2'd3, 32'h0000000F);
    rd_check("debounce cap cleared", 2'd3, 32'd0);

    // Reset while the counter is mid-way; no capture once released at idle.
    in_port = 4'hE;
    tick(6);
    reset_n = 1'b0;
    #1;
    rd_check("db reset data", 2'd0, 32'h0000000F);
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    rd_check("db after reset data", 2'd0, 32'h0000000F);
    rd_check("db after reset cap",  2'd3, 32'd0);
    check("db after reset irq", {31'd0, irq}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
